multibyte_add_sequencer: RTL and testbench
==========================================

// Module: multibyte_add_sequencer
// PURPOSE
//  Sequences two wide operands, one byte per cycle LSB-first, into the team's 8-bit ripple-carry adder.
//  The block sits directly upstream and downstream of that adder: it drives x1/x2/cin and captures y/cout.
//  It chains the carry between bytes and returns the full-width sum and final carry-out.
//  Transfers in and out use valid/ready handshakes; only one operation is in flight at a time.
// PARAMETERS
//  NBYTES  4  operand width in bytes (W = 8*NBYTES); legal range 1..16
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   operand pair offered
//  in_ready   out  1   block can accept an operand pair (high only in IDLE)
//  in_a       in   W   operand A
//  in_b       in   W   operand B
//  in_cin     in   1   carry-in for byte 0
//  add_x1     out  8   to adder x1: current byte of A
//  add_x2     out  8   to adder x2: current byte of B
//  add_cin    out  1   to adder cin: chained carry
//  add_y      in   8   from adder y: byte sum (combinational from add_x1/add_x2/add_cin)
//  add_cout   in   1   from adder cout
//  out_valid  out  1   result available
//  out_ready  in   1   consumer takes the result
//  out_sum    out  W   full-width sum
//  out_cout   out  1   carry-out of the most-significant byte
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, idx=0, carry=0, A/B regs=0, out_sum=0, out_cout=0, out_valid=0.
//   Reset also forces add_x1=0, add_x2=0, add_cin=0. in_ready=1 once rst_n deasserts.
//   Reset mid-operation abandons the operation; no result is produced.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b, set carry<=in_cin, idx<=0, out_sum<=0,
//     out_cout<=0, and go to RUN.
//   RUN: add_x1=A[8*idx+:8], add_x2=B[8*idx+:8], add_cin=carry (combinational from registers).
//     Each cycle: out_sum[8*idx+:8]<=add_y, carry<=add_cout, idx<=idx+1.
//     After the cycle with idx==NBYTES-1: out_cout<=add_cout, go to DONE.
//   DONE: out_valid=1; out_sum/out_cout are held stable. On out_ready, go to IDLE.
//     A new input is not accepted in the same cycle as the output is taken.
//  Outside RUN, add_x1, add_x2 and add_cin are driven 0.
//  in_valid while not in IDLE is ignored (in_ready=0); in_a/in_b changes during RUN have no effect.
//  Latency: accept on edge T; RUN occupies cycles T+1..T+NBYTES; out_valid=1 from edge T+NBYTES.
//   Minimum initiation interval is NBYTES+2 cycles.
//  Arithmetic: out_sum = (in_a + in_b + in_cin) mod 2^W; out_cout = bit W of that sum. Addition is unsigned.
//  idx width is clog2(NBYTES) bits, minimum 1. idx never wraps past NBYTES-1.
//  NBYTES=1: a single RUN cycle.
//  out_valid stays high indefinitely under backpressure (out_ready=0).
// TESTING (NBYTES=4; bench instantiates the 8-bit ripple-carry adder on the add_* ports)
//  1. A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1; carry ripples through all 4 bytes.
//  2. A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0.
//     out_valid rises exactly 4 cycles after the accept edge.
//  3. Backpressure: out_ready=0 for 10 cycles after the result -> out_valid and out_sum held,
//     in_ready=0 throughout. Then out_ready=1 -> IDLE on the next edge.
//  4. in_valid pulsed with A=0xDEADBEEF during RUN -> ignored; the original result is unchanged.
//  5. rst_n pulsed low during RUN at idx=2 -> all outputs 0 immediately, out_valid never asserts.
//     A following op 0x80000000+0x80000000 -> out_sum=0x00000000, out_cout=1.
//  6. 2000 random A/B/cin with random out_ready stalls -> every result equals the {cout,sum} reference model.

Source files
------------

// File: rtl/multibyte_add_sequencer.sv
// Multi-byte add sequencer: streams two NBYTES-wide operands LSB-first through an external
// 8-bit adder, chaining the carry byte to byte, and returns the full-width sum and carry-out.
`timescale 1ns/1ps
module multibyte_add_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  output logic [7:0]            add_x1,
  output logic [7:0]            add_x2,
  output logic                  add_cin,
  input  logic [7:0]            add_y,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout
);

  localparam int unsigned    IdxW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [IdxW-1:0]       r_idx;
  logic                  r_carry;
  logic [8*NBYTES-1:0]   r_a;
  logic [8*NBYTES-1:0]   r_b;
  logic [8*NBYTES-1:0]   r_sum;
  logic                  r_cout;
  logic                  w_accept;
  logic                  w_last;
  logic [IdxW+2:0]       w_base;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_last   = (r_idx == LastIdx);
  // Bit offset of the current byte (idx * 8).
  assign w_base   = {r_idx, 3'b000};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_d = StRun;
      StRun:   if (w_last)    w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default:                w_state_d = StIdle;
    endcase
  end

  // Datapath: latch operands on accept, then fold one adder byte per RUN cycle into the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == StRun) begin
      r_sum[w_base +: 8] <= add_y;
      r_carry            <= add_cout;
      // idx parks on the last byte rather than wrapping; the next accept clears it.
      if (w_last) begin
        r_cout <= add_cout;
      end else begin
        r_idx <= r_idx + IdxW'(1);
      end
    end
  end

  // Outputs: adder inputs are only live in RUN; in_ready is held low while reset is asserted.
  always_comb begin
    add_x1    = 8'h00;
    add_x2    = 8'h00;
    add_cin   = 1'b0;
    in_ready  = (r_state == StIdle) && rst_n;
    out_valid = (r_state == StDone);
    out_sum   = r_sum;
    out_cout  = r_cout;
    if (r_state == StRun) begin
      add_x1  = r_a[w_base +: 8];
      add_x2  = r_b[w_base +: 8];
      add_cin = r_carry;
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed and random bench for multibyte_add_sequencer (NBYTES=4) with an 8-bit ripple adder.
`timescale 1ns/1ps
module tb_multibyte_add_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [7:0]  add_x1;
  logic [7:0]  add_x2;
  logic        add_cin;
  logic [7:0]  add_y;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;

  int n_checks;
  int n_fails;

  multibyte_add_sequencer #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_x1    (add_x1),
    .add_x2    (add_x2),
    .add_cin   (add_cin),
    .add_y     (add_y),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  // 8-bit ripple-carry adder on the add_* ports.
  always_comb begin
    logic c;
    add_y = 8'h00;
    c     = add_cin;
    for (int i = 0; i < 8; i++) begin
      add_y[i] = add_x1[i] ^ add_x2[i] ^ c;
      c        = (add_x1[i] & add_x2[i]) | (c & (add_x1[i] ^ add_x2[i]));
    end
    add_cout = c;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operand pair, wait (bounded) for the result; lat counts negedges after accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] sum, output logic cout, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL run_op_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) begin
      n_checks++;
      n_fails++;
      $display("FAIL run_op_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
    end
    sum  = out_sum;
    cout = out_cout;
  endtask

  // Take the result; afterwards the block must be idle with no result pending.
  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL take_result: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 || in_ready !== 1'b0 ||
        add_x1 !== 8'h00 || add_x2 !== 8'h00 || add_cin !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: ov=%b sum=%h co=%b rdy=%b x1=%h x2=%h ci=%b, want all 0",
               out_valid, out_sum, out_cout, in_ready, add_x1, add_x2, add_cin);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ripple();
    logic [31:0] s; logic c; int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, c, lat);
    n_checks++;
    if (s !== 32'h0000_0000 || c !== 1'b1) begin
      n_fails++;
      $display("FAIL ripple_sum: got %b_%h, want 1_00000000", c, s);
    end
    take_result();
  endtask

  task automatic test_latency();
    logic [31:0] s; logic c; int lat;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, s, c, lat);
    n_checks++;
    if (s !== 32'h2345_678A || c !== 1'b0) begin
      n_fails++;
      $display("FAIL latency_sum: got %b_%h, want 0_2345678a", c, s);
    end
    n_checks++;
    if (lat != 4) begin
      n_fails++;
      $display("FAIL latency_cycles: got %0d, want 4", lat);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    logic [31:0] s; logic c; int lat;
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, s, c, lat);
    n_checks++;
    if (s !== 32'h1010_1010 || c !== 1'b0) begin
      n_fails++;
      $display("FAIL bp_sum: got %b_%h, want 0_10101010", c, s);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h1010_1010 || out_cout !== 1'b0 ||
          in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL bp_hold[%0d]: ov=%b sum=%h co=%b rdy=%b, want 1/10101010/0/0",
                 i, out_valid, out_sum, out_cout, in_ready);
      end
    end
    // Offer a new op in the same cycle the result is taken: it must not be accepted.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h5555_5555;
    in_b      = 32'h1;
    in_cin    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_in_valid();
    logic [31:0] s; logic c; int lat;
    @(negedge clk);
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (add_x1 !== 8'h78 || add_x2 !== 8'h11 || add_cin !== 1'b0) begin
      n_fails++;
      $display("FAIL ignore_byte0: x1=%h x2=%h ci=%b, want 78/11/0", add_x1, add_x2, add_cin);
    end
    in_a = 32'hDEAD_BEEF; in_b = 32'hFFFF_FFFF; in_cin = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL ignore_in_ready: got %b, want 0", in_ready);
    end
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s = out_sum; c = out_cout;
    n_checks++;
    if (s !== 32'h2345_6789 || c !== 1'b0 || out_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL ignore_sum: ov=%b got %b_%h, want 1 0_23456789", out_valid, c, s);
    end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s; logic c; int lat;
    @(negedge clk);
    in_a = 32'h1133_5577; in_b = 32'h2244_6688; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (add_x1 !== 8'h33 || add_x2 !== 8'h44) begin
      n_fails++;
      $display("FAIL midrst_idx2: x1=%h x2=%h, want 33/44", add_x1, add_x2);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (add_x1 !== 8'h00 || add_x2 !== 8'h00 || add_cin !== 1'b0 || out_valid !== 1'b0 ||
        out_sum !== 32'h0 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL midrst_zero: x1=%h x2=%h ci=%b ov=%b sum=%h co=%b rdy=%b, want all 0",
               add_x1, add_x2, add_cin, out_valid, out_sum, out_cout, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fails++;
        $display("FAIL midrst_no_result[%0d]: ov=%b rdy=%b, want 0/1", i, out_valid, in_ready);
      end
    end
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, s, c, lat);
    n_checks++;
    if (s !== 32'h0000_0000 || c !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_followup: got %b_%h, want 1_00000000", c, s);
    end
    take_result();
  endtask

  task automatic test_random();
    logic [31:0] a, b, s; logic cin, c; logic [32:0] exp; int lat, stall;
    for (int n = 0; n < 2000; n++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      exp = {1'b0, a} + {1'b0, b} + {32'h0, cin};
      run_op(a, b, cin, s, c, lat);
      n_checks++;
      if ({c, s} !== exp) begin
        n_fails++;
        $display("FAIL random[%0d]: %h+%h+%b got %h, want %h", n, a, b, cin, {c, s}, exp);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp) begin
          n_fails++;
          $display("FAIL random_stall[%0d]: ov=%b got %h, want 1 %h",
                   n, out_valid, {out_cout, out_sum}, exp);
        end
      end
      take_result();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_ripple();
    test_latency();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
